// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall controller:
// controller state encoding and the control-vector constants that
// describe normal flow, NOP bubble insertion, branch squash and freeze.
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } stall_state_t;

    // Pipeline control vector produced every cycle by the controller.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_hold;
    } ctrl_t;

    // Normal flow: fetch and decode advance, nothing squashed.
    localparam ctrl_t CTRL_RUN = '{
        pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
        idex_bubble: 1'b0, pipe_hold: 1'b0
    };

    // Load-use: PC and IF/ID hold, a NOP bubble enters ID/EX.
    localparam ctrl_t CTRL_BUBBLE = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
        idex_bubble: 1'b1, pipe_hold: 1'b0
    };

    // Taken branch: redirect fetch, squash IF/ID, NOP into ID/EX.
    localparam ctrl_t CTRL_FLUSH = '{
        pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
        idex_bubble: 1'b1, pipe_hold: 1'b0
    };

    // Data-memory freeze: every pipeline register holds its contents.
    localparam ctrl_t CTRL_FREEZE = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
        idex_bubble: 1'b0, pipe_hold: 1'b1
    };

    localparam int unsigned WCNT_W = 8;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-facing bundle of the hazard/stall controller: hazard inputs
// from ID/EX, the MEM-stage data-memory handshake, and the stage enables.
interface hazard_stall_ctrl_if;

    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs2;
    logic       ex_memread;
    logic [4:0] ex_rd;
    logic       ex_branch_taken;
    logic       dmem_req;
    logic       dmem_ready;

    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       pipe_hold;

    // Pipeline datapath side: supplies hazard info, consumes enables.
    modport master (
        output id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd,
               ex_branch_taken, dmem_req, dmem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold
    );

    // Controller side.
    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd,
               ex_branch_taken, dmem_req, dmem_ready,
        output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold
    );

endinterface

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID instruction that reads the register
// a load in EX is about to write. x0 is never a hazard.
module load_use_detect (
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs2,
    output logic       hit
);

    // Purely combinational register-number match.
    always_comb begin
        hit = ex_memread && (ex_rd != 5'd0) &&
              ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and stall controller. Resolves, in priority order,
// data-memory freezes, taken-branch flushes and load-use bubbles, tracks
// data-memory wait time with a sticky timeout, and counts stall cycles.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter logic [7:0]  WAIT_LIMIT = 8'd255,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_stall_ctrl_if.slave   pipe,
    input  logic                 cnt_clr,
    output logic                 timeout_err,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    stall_state_t      state;
    logic [WCNT_W-1:0] wcnt;
    logic              freeze;
    logic              load_use;
    ctrl_t             ctrl;

    load_use_detect u_load_use_detect (
        .ex_memread  (pipe.ex_memread),
        .ex_rd       (pipe.ex_rd),
        .id_rs1      (pipe.id_rs1),
        .id_rs2      (pipe.id_rs2),
        .id_uses_rs2 (pipe.id_uses_rs2),
        .hit         (load_use)
    );

    // Freeze whenever the MEM stage is waiting on data memory.
    always_comb begin
        freeze = 1'b0;
        case (state)
            RUN:      freeze = pipe.dmem_req && !pipe.dmem_ready;
            MEM_WAIT: freeze = !pipe.dmem_ready;
            TIMEOUT:  freeze = 1'b1;
            default:  freeze = 1'b0;
        endcase
    end

    // Control priority: freeze over branch flush over load-use bubble.
    // A branch seen during a freeze is not lost: EX is held and the
    // branch is acted on once the freeze drops.
    always_comb begin
        ctrl = CTRL_RUN;
        if (freeze) begin
            ctrl = CTRL_FREEZE;
        end else if (pipe.ex_branch_taken) begin
            ctrl = CTRL_FLUSH;
        end else if (load_use) begin
            ctrl = CTRL_BUBBLE;
        end
    end

    assign pipe.pc_write    = ctrl.pc_write;
    assign pipe.ifid_write  = ctrl.ifid_write;
    assign pipe.ifid_flush  = ctrl.ifid_flush;
    assign pipe.idex_bubble = ctrl.idex_bubble;
    assign pipe.pipe_hold   = ctrl.pipe_hold;

    // Data-memory wait FSM with wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (pipe.dmem_req && !pipe.dmem_ready) begin
                        state <= MEM_WAIT;
                        wcnt  <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (pipe.dmem_ready) begin
                        state <= RUN;
                        wcnt  <= '0;
                    end else if (wcnt == WAIT_LIMIT) begin
                        state       <= TIMEOUT;
                        timeout_err <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                TIMEOUT: begin
                    timeout_err <= 1'b1;
                end
                default: begin
                    state <= RUN;
                    wcnt  <= '0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC did not advance;
    // a synchronous clear wins over the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (!ctrl.pc_write && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameter WAIT_LIMIT, default 8'd255, maximum consecutive data-memory wait cycles before timeout.
REQ-002 Parameter CNT_W, default 16, width of the stall performance counter.
REQ-003 clk  input  1  rising-edge clock, sole clock domain.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 id_rs1, id_rs2  input  5 each  source register numbers of the instruction in ID.
REQ-006 id_uses_rs2  input  1  ID instruction reads rs2.
REQ-007 ex_memread  input  1  EX instruction is a load.
REQ-008 ex_rd  input  5  destination register of the EX instruction.
REQ-009 ex_branch_taken  input  1  EX resolved a taken branch or jump.
REQ-010 dmem_req, dmem_ready  input  1 each  MEM-stage access request and completion handshake.
REQ-011 cnt_clr  input  1  synchronous clear of stall_cnt.
REQ-012 pc_write, ifid_write  output  1 each  PC and IF/ID register enables.
REQ-013 ifid_flush, idex_bubble  output  1 each  IF/ID squash and ID/EX NOP insertion.
REQ-014 pipe_hold  output  1  freezes ID/EX, EX/MEM and MEM/WB registers.
REQ-015 timeout_err  output  1  sticky data-memory timeout flag.
REQ-016 stall_cnt  output  CNT_W  saturating count of cycles with pc_write=0.

Function
REQ-017 FSM states SHALL be RUN, MEM_WAIT, TIMEOUT; wait counter wcnt SHALL be 8 bits.
REQ-018 Freeze condition F: (state=RUN & dmem_req & !dmem_ready) | (state=MEM_WAIT & !dmem_ready) | state=TIMEOUT.
REQ-019 When F: pc_write=0, ifid_write=0, pipe_hold=1, ifid_flush=0, idex_bubble=0, combinational in the same cycle.
REQ-020 Load-use condition L: ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
REQ-021 When !F & ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1; L is ignored.
REQ-022 When !F & !ex_branch_taken & L: pc_write=0, ifid_write=0, idex_bubble=1, for exactly that cycle.
REQ-023 Otherwise: pc_write=1, ifid_write=1, all other control outputs 0.
REQ-024 Priority SHALL be freeze > branch flush > load-use; a branch coincident with a freeze is deferred, not lost, because the EX register is held.
REQ-025 RUN -> MEM_WAIT when dmem_req & !dmem_ready; wcnt loads 1.
REQ-026 MEM_WAIT: on dmem_ready, the freeze drops in that cycle and the FSM returns to RUN next edge; otherwise wcnt increments.
REQ-027 MEM_WAIT -> TIMEOUT when wcnt==WAIT_LIMIT and dmem_ready=0; timeout_err=1 from the next cycle.
REQ-028 TIMEOUT SHALL hold the freeze and timeout_err until reset; dmem_ready is ignored.
REQ-029 stall_cnt SHALL increment every cycle with pc_write=0 and saturate at all-ones.
REQ-030 cnt_clr SHALL override the stall_cnt increment in the same cycle.
REQ-031 dmem_req asserted with dmem_ready=1 in RUN SHALL cause no freeze.

Reset
REQ-032 rst_n low SHALL force state=RUN, wcnt=0, stall_cnt=0, timeout_err=0 immediately, including mid-wait.
REQ-033 During reset, outputs SHALL reflect RUN with the current inputs.
REQ-034 Release SHALL be synchronous to clk.

Structure
REQ-035 The state encoding and the NOP/bubble constants SHALL live in the shared pipeline package.
REQ-036 The load-use comparator SHALL be a sub-module, load_use_detect.

Verification
REQ-037 ex_memread=1, ex_rd=5, id_rs1=5 -> one cycle with pc_write=0, idex_bubble=1; stall_cnt=1.
REQ-038 ex_rd=0, ex_memread=1, id_rs1=0 -> no stall.
REQ-039 ex_branch_taken=1 together with L true -> ifid_flush=1, idex_bubble=1, pc_write=1.
REQ-040 dmem_req=1 with ready low for 3 cycles, then high -> pipe_hold high for 3 cycles, low on the ready cycle, stall_cnt=3.
REQ-041 WAIT_LIMIT=4, ready never asserted -> TIMEOUT with timeout_err=1 after the 4th wait cycle, freeze held; rst_n low -> all cleared.
REQ-042 stall_cnt forced near saturation with CNT_W=4 -> holds at 15; cnt_clr -> 0.
